csr_file_param: RTL and testbench
=================================

# csr_file_param

Parametrised LoongArch control/status register file for the pipelined CPU core, sitting beside the writeback stage. Holds the exception CSRs (CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY), a configurable bank of SAVE scratch registers, and TID/TCFG/TVAL/TICLR with a width-configurable timer. Unlike the previous generation, it produces the interrupt request, exception entry address and ERTN return address itself, with a defined priority for simultaneous events.

## Interface
- SAVE_NUM, 4, number of SAVE registers, 1..16, mapped at CSR 0x30+i
- TIMER_W, 32, timer counter width, 8..32; TVAL reads are zero-extended
- COREID, 0, reset value of TID
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- csr_num  in  14  CSR address for read and write
- csr_rvalue  out  32  combinational read of the current state; 0 for unmapped addresses
- csr_we  in  1  write enable
- csr_wmask  in  32  per-bit write mask
- csr_wvalue  in  32  write data; each bit stores (wvalue & wmask) | (old & ~wmask)
- wb_ex  in  1  exception commit
- wb_ecode  in  6  exception code
- wb_esubcode  in  9  exception subcode
- wb_pc  in  32  pc of the excepting instruction
- wb_vaddr  in  32  faulting data address
- ertn_flush  in  1  ERTN commit
- hw_int_in  in  8  hardware interrupt lines (level)
- ipi_int_in  in  1  inter-processor interrupt (level)
- has_int  out  1  pending, enabled interrupt
- ex_entry  out  32  EENTRY value
- ertn_pc  out  32  ERA value

## Operation
- Update priority per cycle: reset > wb_ex > ertn_flush > csr_we. A csr_we in the same cycle as wb_ex or ertn_flush is dropped for every CSR those events modify. The exception is IS[11]; see the timer rules.
- CRMD
  - Fields: PLV[1:0], IE[2], DA[3] reads 1, all other bits 0.
  - Reset value: 0x8.
  - wb_ex: PLV<=0, IE<=0.
  - ertn_flush: PLV<=PPLV, IE<=PIE.
- PRMD: PPLV[1:0], PIE[2]. On wb_ex it saves CRMD.PLV and CRMD.IE. Reset value 0.
- ECFG: LIE[12:0]; bits 10 and 31:13 read 0. Reset value 0.
- ESTAT
  - IS[1:0]: software-writable; reset 0.
  - IS[9:2]: register hw_int_in every cycle.
  - IS[10]: reads 0.
  - IS[11]: TI.
  - IS[12]: registers ipi_int_in.
  - Ecode[21:16] and EsubCode[30:22] load on wb_ex.
  - All other bits read 0; only IS[1:0] is writable.
- ERA loads wb_pc on wb_ex. It is also fully writable.
- BADV: on wb_ex with ecode 0x8 (ADEF) it loads wb_pc; with ecode 0x9 (ALE) it loads wb_vaddr. It is writable.
- EENTRY: bits [31:6] writable, [5:0] read 0.
- SAVEi: fully writable. Addresses 0x30+SAVE_NUM..0x3F read 0 and ignore writes.
- TID: fully writable; reset value COREID.
- TCFG: En[0], Periodic[1], InitVal[31:2]. Reset: En=0.
- Timer
  - A TCFG write whose merged En bit is 1 loads TVAL <= {InitVal,2'b00}[TIMER_W-1:0], using the merged write value.
  - When En=1 and TVAL is not all-ones, TVAL decrements by 1 each cycle.
  - When TVAL is 0 and En=1: TI<=1. If Periodic=1, TVAL reloads; otherwise TVAL becomes all-ones and holds.
  - Reset value of TVAL: all-ones.
- TICLR: reads 0. A write with wmask[0]&wvalue[0] clears TI. If a timer hit occurs in the same cycle, TI sets: the set wins.
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).

## Timing
- Reads are zero-latency and combinational. A read in the same cycle as a write returns the old value.
- Writes, wb_ex and ertn_flush take effect at the next rising edge.
- has_int is combinational from registered state. hw_int_in and ipi_int_in reach has_int 1 cycle after they assert.
- Timer interval: a TCFG write with InitVal=N (En=1, N>0) gives TVAL=4N in the cycle after the write. TI is set 4N+1 cycles after that.
- Reset mid-count: asynchronous and immediate. TVAL goes to all-ones, TI to 0, En to 0.
- Outputs at reset:
  - has_int=0.
  - ex_entry and ertn_pc are 0, because EENTRY and ERA reset to 0 in this block.
  - csr_rvalue reflects the reset state.

## Structure
- Package csr_pkg:
  - CSR address constants: CRMD=0x0, PRMD=0x1, ECFG=0x4, ESTAT=0x5, ERA=0x6, BADV=0x7, EENTRY=0xC, SAVE base=0x30, TID=0x40, TCFG=0x41, TVAL=0x42, TICLR=0x44.
  - Ecode constants: ADEF=0x8, ALE=0x9, SYS=0xB, BRK=0xC, INE=0xD, INT=0x0.
  - Field bit positions.
- One sub-module, csr_timer:
  - Owns TCFG and TVAL.
  - Outputs a one-cycle timer_hit pulse to the parent, which owns TI and applies the clear/set rule.

## Test plan
- Reset -> CRMD reads 0x8, TVAL reads 0xFFFFFFFF, TID reads COREID, has_int=0.
- Write ERA 0x1C000100 with wmask 0x0000FFFF over 0 -> reads 0x00000100. Then wb_ex with wb_pc=0x1C000200 -> ERA 0x1C000200, CRMD.PLV=0 and IE=0, PRMD holds the old PLV and IE. Then ertn_flush -> CRMD restored.
- wb_ex with ecode 0x9 and vaddr 0x80001003 -> BADV 0x80001003, ESTAT[21:16]=0x9. With ecode 0x8 -> BADV=wb_pc. A simultaneous csr_we to ERA is ignored.
- TCFG write 0x0000000B (InitVal=2, periodic, En) -> TVAL=8 the next cycle. TI sets 9 cycles later and TVAL reloads to 8. With IE=1 and LIE[11]=1 -> has_int=1. A TICLR write of 1 -> TI=0. A TICLR clear coinciding with a hit -> TI stays 1.
- Non-periodic TCFG 0x5 -> TVAL goes 4..0, then 0xFFFFFFFF and holds. Repeat with TIMER_W=16 -> TVAL reads 0x0000FFFF.
- SAVE_NUM=2: write 0x32 -> reads 0. hw_int_in[3]=1 with LIE[5]=1 and IE=1 -> has_int rises 1 cycle later. An asynchronous reset asserted mid-count -> all state at reset values immediately.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants for the LoongArch CSR file: CSR addresses, exception
// codes, field bit positions and the masked-write merge helper.
package csr_pkg;

    // CSR addresses
    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE   = 14'h030;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    // Exception codes
    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    // Field bit positions
    localparam int CRMD_PLV_LSB     = 0;
    localparam int CRMD_IE          = 2;
    localparam int CRMD_DA          = 3;
    localparam int PRMD_PIE         = 2;
    localparam int ESTAT_IS_TI      = 11;
    localparam int ESTAT_IS_IPI     = 12;
    localparam int ESTAT_ECODE_LSB  = 16;
    localparam int ESTAT_ESUB_LSB   = 22;
    localparam int EENTRY_VA_LSB    = 6;
    localparam int TCFG_EN          = 0;
    localparam int TCFG_PERIODIC    = 1;
    localparam int TCFG_INITVAL_LSB = 2;
    localparam int TICLR_CLR        = 0;

    // LIE bit 10 does not exist
    localparam logic [12:0] ECFG_LIE_MASK = 13'h1BFF;

    // Per-bit masked write: masked bits take the new value, others keep old
    function automatic logic [31:0] merge_bits(input logic [31:0] old_value,
                                               input logic [31:0] wvalue,
                                               input logic [31:0] wmask);
        return (wvalue & wmask) | (old_value & ~wmask);
    endfunction

endpackage

// File: rtl/csr_timer.sv
// Timer block: owns TCFG and TVAL, counts down when enabled and emits a
// single-cycle timer_hit when the count expires. The parent owns TI.
module csr_timer
    import csr_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tcfg_we,
    input  logic [31:0]        wmask,
    input  logic [31:0]        wvalue,
    output logic [31:0]        tcfg_value,
    output logic [TIMER_W-1:0] tval_value,
    output logic               timer_hit
);

    logic [31:0]        tcfg_reg, tcfg_next;
    logic [TIMER_W-1:0] tval_reg, tval_next;
    logic               load;

    // Initial count is InitVal with two zero LSBs, truncated to the counter width
    function automatic logic [TIMER_W-1:0] init_count(input logic [31:0] cfg);
        logic [31:0] full;
        full = {cfg[31:TCFG_INITVAL_LSB], 2'b00};
        return full[TIMER_W-1:0];
    endfunction

    // Next-state: a write with En set restarts the count; otherwise count down,
    // reload or park at all-ones on expiry
    always_comb begin
        tcfg_next = tcfg_reg;
        tval_next = tval_reg;
        if (tcfg_we) begin
            tcfg_next = merge_bits(tcfg_reg, wvalue, wmask);
        end
        load      = tcfg_we && tcfg_next[TCFG_EN];
        timer_hit = !load && tcfg_reg[TCFG_EN] && (tval_reg == '0);
        if (load) begin
            tval_next = init_count(tcfg_next);
        end else if (tcfg_reg[TCFG_EN] && (tval_reg != '1)) begin
            if (tval_reg == '0) begin
                tval_next = tcfg_reg[TCFG_PERIODIC] ? init_count(tcfg_reg) : '1;
            end else begin
                tval_next = tval_reg - TIMER_W'(1);
            end
        end
    end

    // Timer state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcfg_reg <= '0;
            tval_reg <= '1;
        end else begin
            tcfg_reg <= tcfg_next;
            tval_reg <= tval_next;
        end
    end

    assign tcfg_value = tcfg_reg;
    assign tval_value = tval_reg;

endmodule

// File: rtl/csr_file_param.sv
// LoongArch CSR file: exception CSRs, SAVE scratch bank, TID and timer.
// Produces the interrupt request, exception entry and ERTN return address.
// Event priority each cycle: reset > wb_ex > ertn_flush > csr_we.
module csr_file_param
    import csr_pkg::*;
#(
    parameter int          SAVE_NUM = 4,
    parameter int          TIMER_W  = 32,
    parameter logic [31:0] COREID   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic        has_int,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_pc
);

    logic [1:0]  crmd_plv_reg;
    logic        crmd_ie_reg;
    logic [1:0]  prmd_pplv_reg;
    logic        prmd_pie_reg;
    logic [12:0] ecfg_lie_reg;
    logic [1:0]  estat_is_sw_reg;
    logic [7:0]  estat_is_hw_reg;
    logic        estat_ti_reg;
    logic        estat_ipi_reg;
    logic [5:0]  estat_ecode_reg;
    logic [8:0]  estat_esub_reg;
    logic [31:0] era_reg;
    logic [31:0] badv_reg;
    logic [25:0] eentry_reg;
    logic [31:0] tid_reg;
    logic [SAVE_NUM*32-1:0] save_flat;

    logic [31:0]        tcfg_value;
    logic [TIMER_W-1:0] tval_value;
    logic               timer_hit;
    logic [12:0]        estat_is;
    logic [31:0]        wdata_merged;

    // The read port always shows the addressed CSR, so it doubles as the
    // old value for the masked merge
    assign wdata_merged = merge_bits(csr_rvalue, csr_wvalue, csr_wmask);
    assign estat_is = {estat_ipi_reg, estat_ti_reg, 1'b0, estat_is_hw_reg, estat_is_sw_reg};

    csr_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .tcfg_we    (csr_we && (csr_num == CSR_TCFG)),
        .wmask      (csr_wmask),
        .wvalue     (csr_wvalue),
        .tcfg_value (tcfg_value),
        .tval_value (tval_value),
        .timer_hit  (timer_hit)
    );

    // CRMD: exception drops to kernel with interrupts off; ERTN restores
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crmd_plv_reg <= 2'd0;
            crmd_ie_reg  <= 1'b0;
        end else if (wb_ex) begin
            crmd_plv_reg <= 2'd0;
            crmd_ie_reg  <= 1'b0;
        end else if (ertn_flush) begin
            crmd_plv_reg <= prmd_pplv_reg;
            crmd_ie_reg  <= prmd_pie_reg;
        end else if (csr_we && (csr_num == CSR_CRMD)) begin
            crmd_plv_reg <= wdata_merged[CRMD_PLV_LSB +: 2];
            crmd_ie_reg  <= wdata_merged[CRMD_IE];
        end
    end

    // PRMD: snapshot of PLV/IE taken on exception entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prmd_pplv_reg <= 2'd0;
            prmd_pie_reg  <= 1'b0;
        end else if (wb_ex) begin
            prmd_pplv_reg <= crmd_plv_reg;
            prmd_pie_reg  <= crmd_ie_reg;
        end else if (csr_we && (csr_num == CSR_PRMD)) begin
            prmd_pplv_reg <= wdata_merged[1:0];
            prmd_pie_reg  <= wdata_merged[PRMD_PIE];
        end
    end

    // ECFG: local interrupt enables, nonexistent bit 10 forced to zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ecfg_lie_reg <= '0;
        end else if (csr_we && (csr_num == CSR_ECFG)) begin
            ecfg_lie_reg <= wdata_merged[12:0] & ECFG_LIE_MASK;
        end
    end

    // ESTAT: sample interrupt lines, record cause on exception, SW bits writable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estat_is_sw_reg <= 2'd0;
            estat_is_hw_reg <= 8'd0;
            estat_ipi_reg   <= 1'b0;
            estat_ecode_reg <= 6'd0;
            estat_esub_reg  <= 9'd0;
        end else begin
            estat_is_hw_reg <= hw_int_in;
            estat_ipi_reg   <= ipi_int_in;
            if (wb_ex) begin
                estat_ecode_reg <= wb_ecode;
                estat_esub_reg  <= wb_esubcode;
            end else if (csr_we && (csr_num == CSR_ESTAT)) begin
                estat_is_sw_reg <= wdata_merged[1:0];
            end
        end
    end

    // TI: a timer hit sets it and beats a simultaneous TICLR clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estat_ti_reg <= 1'b0;
        end else if (timer_hit) begin
            estat_ti_reg <= 1'b1;
        end else if (csr_we && (csr_num == CSR_TICLR)
                     && csr_wmask[TICLR_CLR] && csr_wvalue[TICLR_CLR]) begin
            estat_ti_reg <= 1'b0;
        end
    end

    // ERA: return address captured on exception, otherwise writable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            era_reg <= '0;
        end else if (wb_ex) begin
            era_reg <= wb_pc;
        end else if (csr_we && (csr_num == CSR_ERA)) begin
            era_reg <= wdata_merged;
        end
    end

    // BADV: faulting address for fetch and alignment faults only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            badv_reg <= '0;
        end else if (wb_ex && (wb_ecode == ECODE_ADEF)) begin
            badv_reg <= wb_pc;
        end else if (wb_ex && (wb_ecode == ECODE_ALE)) begin
            badv_reg <= wb_vaddr;
        end else if (csr_we && (csr_num == CSR_BADV)) begin
            badv_reg <= wdata_merged;
        end
    end

    // EENTRY and TID: plain writable registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eentry_reg <= '0;
            tid_reg    <= COREID;
        end else if (csr_we) begin
            if (csr_num == CSR_EENTRY) begin
                eentry_reg <= wdata_merged[31:EENTRY_VA_LSB];
            end
            if (csr_num == CSR_TID) begin
                tid_reg <= wdata_merged;
            end
        end
    end

    // SAVE scratch bank, one register per implemented address
    generate
        for (genvar gi = 0; gi < SAVE_NUM; gi++) begin : g_save
            localparam logic [13:0] SAVE_ADDR = CSR_SAVE + 14'(gi);
            logic [31:0] save_reg;
            // Scratch register write
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    save_reg <= '0;
                end else if (csr_we && (csr_num == SAVE_ADDR)) begin
                    save_reg <= wdata_merged;
                end
            end
            assign save_flat[gi*32 +: 32] = save_reg;
        end
    endgenerate

    // Combinational read mux; unmapped addresses read zero
    always_comb begin
        csr_rvalue = '0;
        case (csr_num)
            CSR_CRMD:   csr_rvalue = {28'd0, 1'b1, crmd_ie_reg, crmd_plv_reg};
            CSR_PRMD:   csr_rvalue = {29'd0, prmd_pie_reg, prmd_pplv_reg};
            CSR_ECFG:   csr_rvalue = {19'd0, ecfg_lie_reg};
            CSR_ESTAT:  csr_rvalue = {1'b0, estat_esub_reg, estat_ecode_reg, 3'd0, estat_is};
            CSR_ERA:    csr_rvalue = era_reg;
            CSR_BADV:   csr_rvalue = badv_reg;
            CSR_EENTRY: csr_rvalue = {eentry_reg, 6'd0};
            CSR_TID:    csr_rvalue = tid_reg;
            CSR_TCFG:   csr_rvalue = tcfg_value;
            CSR_TVAL:   csr_rvalue = 32'(tval_value);
            default: begin
                for (int i = 0; i < SAVE_NUM; i++) begin
                    if (csr_num == (CSR_SAVE + 14'(i))) begin
                        csr_rvalue = save_flat[i*32 +: 32];
                    end
                end
            end
        endcase
    end

    assign has_int  = crmd_ie_reg && (|(estat_is & ecfg_lie_reg));
    assign ex_entry = {eentry_reg, 6'd0};
    assign ertn_pc  = era_reg;

endmodule

// File: tb/tb_csr_file_param.sv
// Directed bench for csr_file_param: a default-sized instance (a) and a
// small instance (b, SAVE_NUM=2, TIMER_W=16) share stimulus. Expected values
// are queued when a check is issued and popped when the output is sampled.
module tb_csr_file_param;
    import csr_pkg::*;

    logic        clk;
    logic        reset;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] rvalue_a, ex_entry_a, ertn_pc_a;
    logic [31:0] rvalue_b, ex_entry_b, ertn_pc_b;
    logic        has_int_a, has_int_b;

    int total = 0;
    int bad   = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    csr_file_param #(.SAVE_NUM(4), .TIMER_W(32), .COREID(32'h3)) u_dut_a (
        .clk(clk), .reset(reset), .csr_num(csr_num), .csr_rvalue(rvalue_a),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
        .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in), .has_int(has_int_a),
        .ex_entry(ex_entry_a), .ertn_pc(ertn_pc_a)
    );

    csr_file_param #(.SAVE_NUM(2), .TIMER_W(16), .COREID(32'h7)) u_dut_b (
        .clk(clk), .reset(reset), .csr_num(csr_num), .csr_rvalue(rvalue_b),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
        .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in), .has_int(has_int_b),
        .ex_entry(ex_entry_b), .ertn_pc(ertn_pc_b)
    );

    // Long period leaves room for several #1-spaced reads between edges
    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic push_exp(input string tag, input logic [31:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd_a(input string tag, input logic [13:0] addr, input logic [31:0] e);
        csr_num = addr;
        push_exp(tag, e);
        #1;
        pop_cmp(rvalue_a);
        $display("read a %s addr=%h data=%h", tag, addr, rvalue_a);
    endtask

    task automatic rd_b(input string tag, input logic [13:0] addr, input logic [31:0] e);
        csr_num = addr;
        push_exp(tag, e);
        #1;
        pop_cmp(rvalue_b);
        $display("read b %s addr=%h data=%h", tag, addr, rvalue_b);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        push_exp(tag, e);
        pop_cmp(obs);
        $display("check %s value=%h", tag, obs);
    endtask

    task automatic wr(input logic [13:0] addr, input logic [31:0] mask, input logic [31:0] val);
        csr_num = addr; csr_wmask = mask; csr_wvalue = val; csr_we = 1'b1;
        step();
        csr_we = 1'b0;
        $display("write addr=%h mask=%h data=%h", addr, mask, val);
    endtask

    task automatic raise_ex(input logic [5:0] ec, input logic [31:0] pc, input logic [31:0] va);
        wb_ex = 1'b1; wb_ecode = ec; wb_esubcode = 9'h0; wb_pc = pc; wb_vaddr = va;
        step();
        wb_ex = 1'b0;
        $display("exception ecode=%h pc=%h vaddr=%h", ec, pc, va);
    endtask

    initial begin
        reset = 1'b1; csr_num = '0; csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
        wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; wb_vaddr = '0;
        ertn_flush = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;
        step(); step();
        reset = 1'b0;
        step();

        // Reset state
        rd_a("rst_crmd", CSR_CRMD, 32'h8);
        rd_a("rst_tval", CSR_TVAL, 32'hFFFF_FFFF);
        rd_a("rst_tid",  CSR_TID,  32'h3);
        rd_b("rst_tval_b", CSR_TVAL, 32'h0000_FFFF);
        rd_b("rst_tid_b",  CSR_TID,  32'h7);
        chk("rst_has_int", {31'd0, has_int_a}, 32'h0);
        chk("rst_ex_entry", ex_entry_a, 32'h0);
        chk("rst_ertn_pc", ertn_pc_a, 32'h0);

        // Masked ERA write; a same-cycle read still sees the old value
        csr_num = CSR_ERA; csr_wmask = 32'h0000_FFFF; csr_wvalue = 32'h1C00_0100; csr_we = 1'b1;
        push_exp("era_read_during_write", 32'h0);
        #1;
        pop_cmp(rvalue_a);
        step();
        csr_we = 1'b0;
        rd_a("era_masked", CSR_ERA, 32'h0000_0100);

        // Exception entry with a colliding ERA write, then ERTN
        wr(CSR_CRMD, 32'hFFFF_FFFF, 32'h7);
        rd_a("crmd_written", CSR_CRMD, 32'hF);
        csr_num = CSR_ERA; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'hDEAD_BEEF; csr_we = 1'b1;
        raise_ex(ECODE_SYS, 32'h1C00_0200, 32'h0);
        csr_we = 1'b0;
        rd_a("ex_era", CSR_ERA, 32'h1C00_0200);
        rd_a("ex_crmd", CSR_CRMD, 32'h8);
        rd_a("ex_prmd", CSR_PRMD, 32'h7);
        rd_a("ex_estat", CSR_ESTAT, 32'h000B_0000);
        chk("ex_ertn_pc", ertn_pc_a, 32'h1C00_0200);
        ertn_flush = 1'b1;
        step();
        ertn_flush = 1'b0;
        rd_a("ertn_crmd", CSR_CRMD, 32'hF);

        // BADV source selection by ecode
        raise_ex(ECODE_ALE, 32'h1C00_0300, 32'h8000_1003);
        rd_a("ale_badv", CSR_BADV, 32'h8000_1003);
        rd_a("ale_estat", CSR_ESTAT, 32'h0009_0000);
        raise_ex(ECODE_ADEF, 32'h1C00_0400, 32'h0000_0044);
        rd_a("adef_badv", CSR_BADV, 32'h1C00_0400);

        // EENTRY low bits, ECFG hole, SAVE range
        wr(CSR_CRMD, 32'hFFFF_FFFF, 32'h4);
        wr(CSR_EENTRY, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_a("eentry", CSR_EENTRY, 32'hFFFF_FFC0);
        chk("ex_entry", ex_entry_a, 32'hFFFF_FFC0);
        wr(CSR_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_a("ecfg_all", CSR_ECFG, 32'h0000_1BFF);
        chk("no_pending_int", {31'd0, has_int_a}, 32'h0);
        wr(CSR_ECFG, 32'hFFFF_FFFF, 32'h0000_0800);
        wr(14'h033, 32'hFFFF_FFFF, 32'hA5A5_A5A5);
        wr(14'h032, 32'hFFFF_FFFF, 32'h1234_5678);
        wr(14'h031, 32'hFFFF_FFFF, 32'h5555_AAAA);
        rd_a("save3_a", 14'h033, 32'hA5A5_A5A5);
        rd_a("save2_a", 14'h032, 32'h1234_5678);
        rd_b("save3_b", 14'h033, 32'h0);
        rd_b("save2_b", 14'h032, 32'h0);
        rd_b("save1_b", 14'h031, 32'h5555_AAAA);

        // Periodic timer: InitVal=2 -> 8, hit 9 cycles later and reload
        wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
        rd_a("tval_load", CSR_TVAL, 32'h8);
        rd_b("tval_load_b", CSR_TVAL, 32'h8);
        for (int i = 0; i < 8; i++) step();
        rd_a("tval_zero", CSR_TVAL, 32'h0);
        rd_a("ti_not_yet", CSR_ESTAT, 32'h0008_0000);
        step();
        rd_a("ti_set", CSR_ESTAT, 32'h0008_0800);
        rd_a("tval_reload", CSR_TVAL, 32'h8);
        chk("timer_has_int", {31'd0, has_int_a}, 32'h1);
        chk("timer_has_int_b", {31'd0, has_int_b}, 32'h1);
        wr(CSR_TICLR, 32'h1, 32'h1);
        rd_a("ticlr_clears", CSR_ESTAT, 32'h0008_0000);
        rd_a("ticlr_reads0", CSR_TICLR, 32'h0);
        chk("cleared_has_int", {31'd0, has_int_a}, 32'h0);
        for (int i = 0; i < 7; i++) step();
        rd_a("tval_zero2", CSR_TVAL, 32'h0);
        wr(CSR_TICLR, 32'h1, 32'h1);
        rd_a("hit_beats_clear", CSR_ESTAT, 32'h0008_0800);

        // One-shot timer: InitVal=1 -> 4..0 then all-ones and hold
        wr(CSR_TICLR, 32'h1, 32'h1);
        wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0005);
        rd_a("os_tval4", CSR_TVAL, 32'h4);
        for (int n = 3; n >= 0; n--) begin
            step();
            rd_a("os_count", CSR_TVAL, 32'(n));
        end
        rd_a("os_no_ti", CSR_ESTAT, 32'h0008_0000);
        step();
        rd_a("os_expired", CSR_TVAL, 32'hFFFF_FFFF);
        rd_b("os_expired_b", CSR_TVAL, 32'h0000_FFFF);
        rd_a("os_ti", CSR_ESTAT, 32'h0008_0800);
        step();
        rd_a("os_hold", CSR_TVAL, 32'hFFFF_FFFF);
        wr(CSR_TICLR, 32'h1, 32'h1);

        // Software IS bits
        wr(CSR_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_a("estat_sw", CSR_ESTAT, 32'h0008_0003);
        wr(CSR_ESTAT, 32'h3, 32'h0);

        // Hardware interrupt line reaches has_int one cycle later
        wr(CSR_ECFG, 32'hFFFF_FFFF, 32'h0000_0020);
        hw_int_in = 8'h08;
        #1;
        chk("hw_int_same_cycle", {31'd0, has_int_a}, 32'h0);
        step();
        chk("hw_int_next_cycle", {31'd0, has_int_a}, 32'h1);
        chk("hw_int_next_cycle_b", {31'd0, has_int_b}, 32'h1);
        rd_a("estat_hw", CSR_ESTAT, 32'h0008_0020);
        hw_int_in = 8'h00;
        step();
        chk("hw_int_drop", {31'd0, has_int_a}, 32'h0);

        // Inter-processor interrupt
        ipi_int_in = 1'b1;
        wr(CSR_ECFG, 32'hFFFF_FFFF, 32'h0000_1000);
        chk("ipi_int", {31'd0, has_int_a}, 32'h1);
        ipi_int_in = 1'b0;
        step();

        // Asynchronous reset in the middle of a count
        wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0101);
        step(); step();
        rd_a("mid_count", CSR_TVAL, 32'h0000_00FE);
        #2;
        reset = 1'b1;
        rd_a("arst_tval", CSR_TVAL, 32'hFFFF_FFFF);
        rd_a("arst_tcfg", CSR_TCFG, 32'h0);
        rd_a("arst_crmd", CSR_CRMD, 32'h8);
        rd_a("arst_estat", CSR_ESTAT, 32'h0);
        rd_a("arst_save3", 14'h033, 32'h0);
        rd_b("arst_tval_b", CSR_TVAL, 32'h0000_FFFF);
        chk("arst_ertn_pc", ertn_pc_a, 32'h0);
        chk("arst_ex_entry", ex_entry_a, 32'h0);
        chk("arst_has_int", {31'd0, has_int_a}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
